// File: rtl/systolic_array_nxn.sv
// N x N output-stationary systolic matmul engine (C = A*B, K programmable per job).
// Operands stream in as columns of A / rows of B; the saturated, optionally ReLU'd result is held until accepted.
module systolic_array_nxn #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int KLEN_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [KLEN_W-1:0]        k_len,
    input  logic                     relu_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*DATA_W-1:0]      a_col,
    input  logic [N*DATA_W-1:0]      b_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*N*OUT_W-1:0]     c_flat,
    output logic                     sat_flag,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DCNT_W = $clog2(2 * N);
    localparam logic [DCNT_W-1:0] DRAIN_LAST_C = DCNT_W'(2 * N - 2);
    localparam logic signed [ACC_W-1:0] OUT_MAX_C = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN_C = ~OUT_MAX_C;

    // Returns {saturated, result}: ReLU first, then clamp into the signed OUT_W range.
    function automatic logic [OUT_W:0] sat_relu(input logic signed [ACC_W-1:0] acc, input logic relu);
        logic signed [ACC_W-1:0] v;
        logic [OUT_W:0]          r;
        v = (relu && acc[ACC_W-1]) ? {ACC_W{1'b0}} : acc;
        if (v > OUT_MAX_C) begin
            r = {1'b1, OUT_MAX_C[OUT_W-1:0]};
        end else if (v < OUT_MIN_C) begin
            r = {1'b1, OUT_MIN_C[OUT_W-1:0]};
        end else begin
            r = {1'b0, v[OUT_W-1:0]};
        end
        return r;
    endfunction

    state_t                    state_r, next_state_s;
    logic [KLEN_W-1:0]         k_len_r, k_cnt_r;
    logic                      relu_r;
    logic [DCNT_W-1:0]         drain_cnt_r;
    logic                      in_ready_r, busy_r, out_valid_r, sat_flag_r;
    logic [N*N*OUT_W-1:0]      c_flat_r, c_next_s;
    logic                      sat_next_s;
    logic                      accept_s, clear_s, capture_s;

    logic signed [DATA_W-1:0]   a_inj_s  [N];
    logic signed [DATA_W-1:0]   b_inj_s  [N];
    logic signed [DATA_W-1:0]   a_skew_r [N][N-1];
    logic signed [DATA_W-1:0]   b_skew_r [N][N-1];
    logic signed [DATA_W-1:0]   a_edge_s [N];
    logic signed [DATA_W-1:0]   b_edge_s [N];
    logic signed [DATA_W-1:0]   a_op_s   [N][N];
    logic signed [DATA_W-1:0]   b_op_s   [N][N];
    logic signed [DATA_W-1:0]   a_pe_r   [N][N-1];
    logic signed [DATA_W-1:0]   b_pe_r   [N-1][N];
    logic signed [2*DATA_W-1:0] prod_s   [N][N];
    logic signed [ACC_W-1:0]    acc_r    [N][N];

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign sat_flag  = sat_flag_r;
    assign c_flat    = c_flat_r;

    // in_ready_r mirrors the FEED state, so it doubles as the beat-accept qualifier.
    assign accept_s  = in_valid & in_ready_r;
    assign capture_s = (state_r == ST_DONE) & ~out_valid_r;

    // Next-state logic for the job sequence IDLE -> FEED -> DRAIN -> DONE.
    always_comb begin
        next_state_s = state_r;
        clear_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    clear_s = 1'b1;
                    if (k_len == {KLEN_W{1'b0}}) begin
                        next_state_s = ST_DRAIN;
                    end else begin
                        next_state_s = ST_FEED;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (accept_s && (k_cnt_r == k_len_r - KLEN_W'(1'b1))) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_FEED;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST_C) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (out_valid_r && out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Control registers: state, job settings, counters and the registered result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            k_len_r     <= {KLEN_W{1'b0}};
            k_cnt_r     <= {KLEN_W{1'b0}};
            relu_r      <= 1'b0;
            drain_cnt_r <= {DCNT_W{1'b0}};
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            sat_flag_r  <= 1'b0;
            c_flat_r    <= {(N*N*OUT_W){1'b0}};
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s == ST_FEED);
            busy_r     <= (next_state_s != ST_IDLE);
            if (clear_s) begin
                k_len_r <= k_len;
                relu_r  <= relu_en;
                k_cnt_r <= {KLEN_W{1'b0}};
            end else if (accept_s) begin
                k_cnt_r <= k_cnt_r + KLEN_W'(1'b1);
            end
            if (state_r == ST_DRAIN) begin
                drain_cnt_r <= drain_cnt_r + DCNT_W'(1'b1);
            end else begin
                drain_cnt_r <= {DCNT_W{1'b0}};
            end
            // The result is sampled one cycle into DONE so the final MAC has settled in acc_r.
            if (capture_s) begin
                out_valid_r <= 1'b1;
                c_flat_r    <= c_next_s;
                sat_flag_r  <= sat_next_s;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Operand injection: anything other than an accepted beat enters the array as zero.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (accept_s) begin
                a_inj_s[i] = $signed(a_col[i*DATA_W +: DATA_W]);
                b_inj_s[i] = $signed(b_row[i*DATA_W +: DATA_W]);
            end else begin
                a_inj_s[i] = {DATA_W{1'b0}};
                b_inj_s[i] = {DATA_W{1'b0}};
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_edge
            if (gi == 0) begin : g_nodelay
                assign a_edge_s[gi] = a_inj_s[gi];
                assign b_edge_s[gi] = b_inj_s[gi];
            end else begin : g_delay
                assign a_edge_s[gi] = a_skew_r[gi][gi-1];
                assign b_edge_s[gi] = b_skew_r[gi][gi-1];
            end
            for (gj = 0; gj < N; gj++) begin : g_pe
                if (gj == 0) begin : g_a_west
                    assign a_op_s[gi][gj] = a_edge_s[gi];
                end else begin : g_a_pass
                    assign a_op_s[gi][gj] = a_pe_r[gi][gj-1];
                end
                if (gi == 0) begin : g_b_north
                    assign b_op_s[gi][gj] = b_edge_s[gj];
                end else begin : g_b_pass
                    assign b_op_s[gi][gj] = b_pe_r[gi-1][gj];
                end
                assign prod_s[gi][gj] = a_op_s[gi][gj] * b_op_s[gi][gj];
            end
        end
    endgenerate

    // Datapath: skew lines, PE forwarding registers and wrapping accumulators.
    always_ff @(posedge clk) begin
        if (rst || clear_s) begin
            for (int i = 0; i < N; i++) begin
                for (int d = 0; d < N - 1; d++) begin
                    a_skew_r[i][d] <= {DATA_W{1'b0}};
                    b_skew_r[i][d] <= {DATA_W{1'b0}};
                    a_pe_r[i][d]   <= {DATA_W{1'b0}};
                    b_pe_r[d][i]   <= {DATA_W{1'b0}};
                end
                for (int j = 0; j < N; j++) begin
                    acc_r[i][j] <= {ACC_W{1'b0}};
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                a_skew_r[i][0] <= a_inj_s[i];
                b_skew_r[i][0] <= b_inj_s[i];
                for (int d = 1; d < N - 1; d++) begin
                    a_skew_r[i][d] <= a_skew_r[i][d-1];
                    b_skew_r[i][d] <= b_skew_r[i][d-1];
                end
                for (int j = 0; j < N - 1; j++) begin
                    a_pe_r[i][j] <= a_op_s[i][j];
                    b_pe_r[j][i] <= b_op_s[j][i];
                end
                for (int j = 0; j < N; j++) begin
                    acc_r[i][j] <= acc_r[i][j] + ACC_W'(prod_s[i][j]);
                end
            end
        end
    end

    // Output stage: per-element ReLU and clamp, with the saturation flags OR-reduced.
    always_comb begin
        logic [OUT_W:0] res_v;
        c_next_s   = {(N*N*OUT_W){1'b0}};
        sat_next_s = 1'b0;
        res_v      = {(OUT_W+1){1'b0}};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                res_v = sat_relu(acc_r[i][j], relu_r);
                c_next_s[(i*N+j)*OUT_W +: OUT_W] = res_v[OUT_W-1:0];
                sat_next_s = sat_next_s | res_v[OUT_W];
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Scoreboard bench for systolic_array_nxn: the driver pushes model results, a monitor checks every
// cycle the DUT presents out_valid, including latency and stability while out_ready is held low.
module tb_systolic_array_nxn;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 16;
    localparam int KLEN_W = 8;
    localparam int KMAX   = 8;
    localparam int CW     = N * N * OUT_W;

    logic                clk = 1'b0;
    logic                rst, start, relu_en, in_valid, out_ready;
    logic [KLEN_W-1:0]   k_len;
    logic [N*DATA_W-1:0] a_col, b_row;
    logic                in_ready, out_valid, sat_flag, busy;
    logic [CW-1:0]       c_flat;

    systolic_array_nxn #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .KLEN_W(KLEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready), .c_flat(c_flat),
        .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CW-1:0] c;
        logic          sat;
        int            lat;
        int            hold;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ref_cyc  = 0;
    int   A_m [N][KMAX];
    int   B_m [KMAX][N];

    function automatic void check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: compare each presented result with the queue head; release out_ready after the hold.
    initial begin
        int hold_left;
        bit first;
        out_ready = 1'b0;
        hold_left = 0;
        first     = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                out_ready = 1'b0;
                first     = 1'b1;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result");
                end else begin
                    if (first) begin
                        first     = 1'b0;
                        hold_left = exp_q[0].hold;
                        if (exp_q[0].lat >= 0)
                            check({exp_q[0].name, "_latency"}, CW'(cyc - ref_cyc), CW'(exp_q[0].lat));
                    end
                    check({exp_q[0].name, "_c"}, c_flat, exp_q[0].c);
                    check({exp_q[0].name, "_sat"}, CW'(sat_flag), CW'(exp_q[0].sat));
                    if (hold_left == 0) begin
                        out_ready = 1'b1;
                        void'(exp_q.pop_front());
                        first = 1'b1;
                    end else begin
                        hold_left--;
                    end
                end
            end else begin
                out_ready = 1'b0;
            end
        end
    end

    task automatic clear_mats();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                A_m[i][k] = 0;
                B_m[k][i] = 0;
            end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                A_m[i][k] = int'($urandom_range(0, 255)) - 128;
                B_m[k][i] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic fill_const(input int a, input int b);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                A_m[i][k] = a;
                B_m[k][i] = b;
            end
    endtask

    task automatic drive_beat(input int kk);
        for (int i = 0; i < N; i++) begin
            a_col[i*DATA_W +: DATA_W] = A_m[i][kk][DATA_W-1:0];
            b_row[i*DATA_W +: DATA_W] = B_m[kk][i][DATA_W-1:0];
        end
    endtask

    // Full job: model the result, queue it, drive start and K beats, then wait for the monitor.
    task automatic run_job(input string name, input int k, input bit relu, input int p_bub,
                           input int hold, input bit poke_start);
        exp_t e;
        int   kk, guard;
        e.c = '0;
        e.sat = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                longint s;
                int     v, cv;
                s = 0;
                for (int t = 0; t < k; t++) s += longint'(A_m[i][t]) * longint'(B_m[t][j]);
                v = int'(s);
                if (relu && v < 0) v = 0;
                if (v > 32767) begin cv = 32767; e.sat = 1'b1; end
                else if (v < -32768) begin cv = -32768; e.sat = 1'b1; end
                else cv = v;
                e.c[(i*N+j)*OUT_W +: OUT_W] = cv[OUT_W-1:0];
            end
        // k = 0: start cycle + (2N-1) DRAIN cycles + capture cycle; otherwise K + 2N from the first beat.
        e.lat  = (p_bub != 0) ? -1 : ((k == 0) ? 2 * N + 1 : k + 2 * N);
        e.hold = hold;
        e.name = name;
        exp_q.push_back(e);

        @(negedge clk);
        start = 1'b1; k_len = KLEN_W'(k); relu_en = relu;
        ref_cyc = cyc;
        @(negedge clk);
        k_len = KLEN_W'($urandom); relu_en = ~relu;
        kk = 0; guard = 0;
        while (kk < k && guard < 1000) begin
            start = (poke_start && kk == 2) ? 1'b1 : 1'b0;
            if (int'($urandom_range(0, 99)) < p_bub) begin
                in_valid = 1'b0;
                a_col = $urandom; b_row = $urandom;
            end else begin
                in_valid = 1'b1;
                drive_beat(kk);
            end
            if (in_valid && in_ready) begin
                if (kk == 0) ref_cyc = cyc;
                kk++;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        if (kk < k) begin
            n_checks++; n_fail++;
            $display("FAIL %s_feed_timeout: got %0d beats expected %0d", name, kk, k);
        end
        if (k > 0) begin
            check({name, "_in_ready_after_k"}, CW'(in_ready), CW'(0));
            // Beats offered after the K-th must be ignored.
            in_valid = 1'b1; a_col = $urandom; b_row = $urandom;
            @(negedge clk);
            a_col = $urandom; b_row = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0; a_col = '0; b_row = '0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s_done_timeout: got %0d pending results expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        rst = 1'b1; start = 1'b0; k_len = '0; relu_en = 1'b0; in_valid = 1'b0;
        a_col = '0; b_row = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", CW'(in_ready), CW'(0));
        check("rst_out_valid", CW'(out_valid), CW'(0));
        check("rst_busy", CW'(busy), CW'(0));
        check("rst_sat_flag", CW'(sat_flag), CW'(0));
        check("rst_c_flat", c_flat, CW'(0));
        rst = 1'b0;

        // 2x2 product in the top-left corner with an identity B.
        clear_mats();
        A_m[0][0] = 1; A_m[0][1] = 2; A_m[1][0] = 3; A_m[1][1] = 4;
        B_m[0][0] = 1; B_m[1][1] = 1;
        run_job("s1_identity", 2, 1'b0, 0, 0, 1'b0);

        fill_rand();
        run_job("s2_rand_hold5", 8, 1'b0, 40, 5, 1'b0);
        fill_rand();
        run_job("s2_rand_hold2", 8, 1'b1, 40, 2, 1'b0);

        clear_mats();
        A_m[0][0] = -3; A_m[1][0] = 5; B_m[0][0] = 2; B_m[0][1] = 4;
        run_job("s3_relu_on", 1, 1'b1, 0, 0, 1'b0);
        run_job("s3_relu_off", 1, 1'b0, 0, 1, 1'b0);

        fill_const(127, 127);
        run_job("s4_sat_pos", 4, 1'b0, 0, 0, 1'b0);
        fill_const(-128, 127);
        run_job("s4_sat_neg", 4, 1'b0, 0, 0, 1'b0);
        run_job("s4_neg_relu", 4, 1'b1, 0, 0, 1'b0);

        fill_rand();
        run_job("s5_k0", 0, 1'b0, 0, 0, 1'b0);
        run_job("s5_start_in_feed", 8, 1'b0, 0, 0, 1'b1);

        // Abort a K=8 job after three beats.
        fill_rand();
        @(negedge clk);
        start = 1'b1; k_len = KLEN_W'(8); relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        beats = 0;
        for (int g = 0; g < 20 && beats < 3; g++) begin
            in_valid = 1'b1;
            drive_beat(beats);
            if (in_ready) beats++;
            @(negedge clk);
        end
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("s6_abort_busy", CW'(busy), CW'(0));
        check("s6_abort_in_ready", CW'(in_ready), CW'(0));
        check("s6_abort_out_valid", CW'(out_valid), CW'(0));
        rst = 1'b0;
        clear_mats();
        A_m[0][0] = 1; A_m[0][1] = 2; A_m[1][0] = 3; A_m[1][1] = 4;
        B_m[0][0] = 1; B_m[1][1] = 1;
        run_job("s6_after_abort", 2, 1'b0, 0, 0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            fill_rand();
            run_job($sformatf("rand_job%0d", r), int'($urandom_range(1, KMAX)),
                    1'($urandom_range(0, 1)), 30, int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
